spi_mem_slave: RTL

Serial memory target for the SPI memory subsystem. Sits directly downstream of the SPI master on the cs/mosi/miso/ready/op_done wires. It deserialises write and read command frames into a 32 x 8 register memory. It acknowledges writes with op_done, and answers reads with a ready pulse followed by 8 serial data bits.

---
 rtl/spi_mem_if.sv | 12 +
 rtl/spi_mem_slave.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/spi_mem_if.sv
// Serial link between the SPI master and the memory target: chip select,
// data in both directions, and the two handshake pulses.
interface spi_mem_if;
  logic cs;
  logic mosi;
  logic miso;
  logic ready;
  logic op_done;

  modport master (output cs, output mosi, input miso, input ready, input op_done);
  modport slave  (input cs, input mosi, output miso, output ready, output op_done);
endinterface

// File: rtl/spi_mem_slave.sv
// SPI memory target: deserialises LSB-first write/read frames into a 32 x 8
// register file, acks writes with op_done and answers reads with ready + 8 bits.
module spi_mem_slave (
  input  logic     clk,
  input  logic     rstn,
  spi_mem_if.slave bus
);
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RX_CMD,
    RX_ADDR,
    RX_DATA,
    WRITE,
    READ,
    TX_DATA
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] tx_q, tx_d;
  logic       miso_q, miso_d;
  logic       ready_q, ready_d;
  logic       op_done_q, op_done_d;
  logic       mem_we;
  logic       addr_ok;
  logic [3:0] addr_last;
  logic [7:0] mem [DEPTH];

  // Upper address bits must be zero for the access to hit the register file.
  assign addr_ok   = (addr_q[7:AW] == '0);
  assign addr_last = wr_q ? 4'd7 : 4'd6;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_d      = tx_q;
    miso_d    = 1'b0;
    ready_d   = 1'b0;
    op_done_d = 1'b0;
    mem_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.cs) state_d = RX_CMD;
      end
      RX_CMD: begin
        if (bus.cs) begin
          state_d = IDLE;
        end else begin
          wr_d    = bus.mosi;
          addr_d  = '0;
          data_d  = '0;
          cnt_d   = '0;
          state_d = RX_ADDR;
        end
      end
      RX_ADDR: begin
        if (bus.cs) begin
          state_d = IDLE;
        end else begin
          addr_d[cnt_q[2:0]] = bus.mosi;
          cnt_d              = cnt_q + 4'd1;
          if (cnt_q == addr_last) begin
            cnt_d   = '0;
            state_d = wr_q ? RX_DATA : READ;
          end
        end
      end
      RX_DATA: begin
        if (bus.cs) begin
          state_d = IDLE;
        end else begin
          data_d[cnt_q[2:0]] = bus.mosi;
          cnt_d              = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // Out-of-range writes are dropped but still acknowledged.
        mem_we    = addr_ok;
        op_done_d = 1'b1;
        state_d   = IDLE;
      end
      READ: begin
        tx_d    = addr_ok ? mem[addr_q[AW-1:0]] : '0;
        ready_d = 1'b1;
        cnt_d   = '0;
        state_d = TX_DATA;
      end
      TX_DATA: begin
        if (cnt_q == 4'd8) begin
          state_d = IDLE;
        end else begin
          miso_d = tx_q[cnt_q[2:0]];
          cnt_d  = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      ready_q   <= ready_d;
      op_done_q <= op_done_d;
    end
  end

  // NOTE: the register file sits in the async reset because it must read back zeros after rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr_q[AW-1:0]] <= data_q;
    end
  end

  assign bus.miso    = miso_q;
  assign bus.ready   = ready_q;
  assign bus.op_done = op_done_q;
endmodule
